div_repeated_sub: RTL and testbench

- Unsigned integer divider that works by repeated subtraction: the inverse of the multiply-by-repeated-addition unit.
- Contains datapath (remainder register, divisor register, quotient counter, subtractor, comparator) and its controlling FSM in one block.
- Operands arrive sequentially over a single shared input bus: dividend first, divisor on the next cycle.
- Handshake is start/done; results hold until the next operation.

---
 rtl/div_repeated_sub.sv | 69 ++++++
 tb/tb_div_repeated_sub.sv | 109 ++++++++++
 2 files changed

// File: rtl/div_repeated_sub.sv
// div_repeated_sub: unsigned divider by repeated subtraction, operands over one shared bus, start/done handshake
module div_repeated_sub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  typedef enum logic [1:0] {IDLE, LOAD_B, SUB, DONE} state_t;
  state_t state_q;
  logic [WIDTH-1:0] r_q, d_q, q_q, r_d;
  logic busy_q, done_q, dz_q;
  assign r_d = r_q - d_q;
  assign busy = busy_q;
  assign done = done_q;
  assign div_by_zero = dz_q;
  assign quotient = q_q;
  assign remainder = r_q;
  // Controller and datapath: one subtract-or-finish decision per edge while in SUB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      r_q <= '0;
      d_q <= '0;
      q_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          r_q <= data_in;
          q_q <= '0;
          dz_q <= 1'b0;
          busy_q <= 1'b1;
          state_q <= LOAD_B;
        end
        LOAD_B: begin
          d_q <= data_in;
          state_q <= SUB;
        end
        SUB: if (d_q == '0) begin
          q_q <= '1;
          dz_q <= 1'b1;
          done_q <= 1'b1;
          state_q <= DONE;
        end else if (r_q >= d_q) begin
          r_q <= r_d;
          q_q <= q_q + 1'b1;
        end else begin
          done_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_repeated_sub.sv
// tb_div_repeated_sub: directed self-checking bench for div_repeated_sub
module tb_div_repeated_sub;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [15:0] data_in = '0;
  logic busy, done, div_by_zero;
  logic [15:0] quotient, remainder;
  int checks = 0;
  int errors = 0;

  div_repeated_sub #(.WIDTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .data_in(data_in),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero),
    .quotient(quotient),
    .remainder(remainder)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Edges are counted from the start-accepting edge (edge 0); done must appear after edge ee.
  task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] eq, input logic [15:0] er, input logic edz,
                     input int ee, input bit noise);
    int e;
    @(negedge clk);
    start = 1'b1;
    data_in = a;
    @(negedge clk);
    e = 0;
    start = 1'b0;
    data_in = b;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_nodone"}, done, 0);
    while (!done && e < 70000) begin
      @(negedge clk);
      e++;
      data_in = 16'hA5A5;
      start = noise && e >= 2 && (e % 3 == 0);
    end
    start = 1'b0;
    chk({tag, "_lat"}, e, ee);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_dz"}, div_by_zero, edz);
    chk({tag, "_busydone"}, busy, 1);
    @(negedge clk);
    chk({tag, "_pulse"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
    @(negedge clk);
    chk({tag, "_holdq"}, quotient, eq);
    chk({tag, "_holdr"}, remainder, er);
    chk({tag, "_holddone"}, done, 0);
  endtask

  initial begin
    int e;
    #1 rst = 1'b1;
    #1;
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    run("d100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 16, 1'b0);
    run("d5_9", 16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 2, 1'b0);
    run("d0_3", 16'd0, 16'd3, 16'd0, 16'd0, 1'b0, 2, 1'b0);
    run("d42_0", 16'd42, 16'd0, 16'hFFFF, 16'd42, 1'b1, 2, 1'b0);
    run("d9_3", 16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 5, 1'b0);
    run("d1000_3n", 16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 335, 1'b1);
    run("d65535_1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 65537, 1'b0);
    @(negedge clk);
    start = 1'b1;
    data_in = 16'd1000;
    @(negedge clk);
    start = 1'b0;
    data_in = 16'd3;
    for (e = 0; e < 7; e++) @(negedge clk);
    chk("mid_q", quotient, 6);
    chk("mid_r", remainder, 982);
    #2 rst = 1'b1;
    #1;
    chk("arst_q", quotient, 0);
    chk("arst_r", remainder, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("arst_hold", busy, 0);
    run("d20_6", 16'd20, 16'd6, 16'd3, 16'd2, 1'b0, 5, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
